pair_and_sched: RTL and testbench
=================================

# pair_and_sched

Round-robin scheduler that shares one two-stage pair-AND register datapath between NREQ requesters. Each requester presents a 4-bit word. The block grants one requester per cycle and registers the granted word in a capture stage. It then reduces the word to two bits, {d[3]&d[2], d[1]&d[0]}, in an output stage and delivers the result with the requester's ID under valid/ready backpressure. It sits between the requester fabric and downstream 2-bit consumers and replaces direct, unshared instances of the capture/reduce pipeline.

## Interface
- NREQ, 4, number of requesters; legal range 2..8
- IDW, 2, ID width; must satisfy 2^IDW >= NREQ
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req  input  NREQ  request per requester; bit i is requester i
- data  input  4*NREQ  word of requester i on data[4*i+3:4*i]
- gnt  output  NREQ  one-hot grant; combinational; requester i's word is accepted on the clock edge ending a cycle with gnt[i]=1
- out_valid  output  1  out and out_id hold a result
- out_ready  input  1  consumer accepts the result this cycle
- out  output  2  {d[3]&d[2], d[1]&d[0]} of the granted word
- out_id  output  IDW  index of the requester that produced out
- busy  output  1  s1_valid | out_valid

## Operation
- Interface decisions: one clock, `clk`. Reset `rst` is synchronous and active-high.
- Advance condition:
  - adv = !out_valid | out_ready.
  - Both stages move only when adv=1. When adv=0 the whole pipeline holds.
- Arbiter:
  - When adv=1 and |req, gnt selects the first requester with req set, searching upward and wrapping from ptr.
  - Otherwise gnt=0.
  - gnt is never asserted for a requester whose req=0.
  - At most one gnt bit is set.
- Pointer:
  - On an edge with a grant to requester k, ptr <= (k+1) mod NREQ.
  - Otherwise ptr holds.
  - ptr wraps NREQ-1 -> 0.
- Stage 1 (capture), on adv:
  - s1_valid <= |gnt.
  - s1_data <= the granted word.
  - s1_id <= k.
- Stage 2 (reduce), on adv:
  - out_valid <= s1_valid.
  - out <= {s1_data[3]&s1_data[2], s1_data[1]&s1_data[0]}.
  - out_id <= s1_id.
  - When s1_valid=0, out and out_id also load 0 (out_valid=0 in that case).
- No states beyond the two valid bits. Effective pipeline states: EMPTY, S1, S2, FULL, each determined by {s1_valid, out_valid}.
- Fairness: a requester holding req continuously is granted within NREQ-1 grants to others.
- Requester contract: hold req and data stable until gnt. Dropping req before gnt is legal; no grant is then issued to that requester.
- Reset values:
  - gnt=0, out_valid=0, out=0, out_id=0, busy=0.
  - s1_valid=0, s1_data=0, s1_id=0.
  - ptr=0, so requester 0 has highest priority after reset.
- Reset mid-operation: in-flight words are discarded, with no output. Requesters granted before reset are not re-granted unless they request again.

## Timing
- Latency: a word granted in cycle N gives out_valid=1 in cycle N+2 when no stall occurs.
- Throughput: one result per cycle while out_ready=1 and req is non-zero.
- Stall:
  - out_valid=1 and out_ready=0 gives adv=0: gnt=0, all registers hold, ptr holds.
  - Bubble in stage 1 with out_valid=1 and out_ready=0: still adv=0, so the bubble is not squeezed out. This is intentional and keeps the logic simple.
- Simultaneous events:
  - A grant and output acceptance in the same cycle are both honoured.
  - An out_ready pulse with out_valid=0 has no effect.
- gnt depends combinationally on req, ptr, out_valid and out_ready. There is no path from data to gnt.

## Configuration
- PAIR_SCHED_PARITY_EN:
  - Defined: adds output out_par (1 bit), registered with out. out_par = ^s1_data, the even parity of the full 4-bit source word. Reset value 0; it follows the out/out_id rules.
  - Undefined: the port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset, then req=4'b0000 for 5 cycles -> gnt=0, out_valid=0, out=0, out_id=0, busy=0 throughout.
- Single-word latency: req=4'b0100, data[11:8]=4'hD, out_ready=1 -> gnt=4'b0100 in cycle N, out_valid=1 with out=2'b10 and out_id=2 in N+2, out_valid=0 in N+3.
- Round-robin: req=4'b1111 held, words 4'hF/4'h3/4'hC/4'h0 for requesters 0..3, out_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; out sequence 11,01,10,00 with out_ids 0,1,2,3.
- Backpressure: during full-rate traffic, drop out_ready for 3 cycles -> gnt=0, out/out_id/out_valid frozen, and no result lost or duplicated after release.
- Wrap and fairness: after a grant to requester 3, req=4'b1001 -> requester 0 is granted next, then 3. Requester 3 holding req alongside 0..2 waits at most 3 grants.
- Reset mid-flight: assert rst for one cycle with both stages valid -> next cycle out_valid=0 and busy=0. With PAIR_SCHED_PARITY_EN defined, out_par=0 after reset, and word 4'h7 yields out_par=1.

Source files
------------

// File: rtl/pair_and_sched.sv
// pair_and_sched
// Round-robin scheduler in front of a shared two-stage pair-AND pipeline.
// Each cycle one requester is granted. Its 4-bit word is captured in stage 1.
// Stage 2 reduces the word to {d[3]&d[2], d[1]&d[0]} and presents it with the
// requester ID under valid/ready handshaking.
//
// Parameters:
//   NREQ  number of requesters (2..8)
//   IDW   ID width, 2**IDW >= NREQ
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   req        request per requester (bit i = requester i)
//   data       requester i word on data[4*i+3:4*i]
//   gnt        one-hot grant (combinational); the word is taken on the edge
//              that ends a cycle with gnt[i]=1
//   out_valid  out/out_id hold a result
//   out_ready  consumer accepts the result this cycle
//   out        pair-AND of the granted word
//   out_id     requester index for out
//   busy       either pipeline stage holds a word
//   out_par    (only with PAIR_SCHED_PARITY_EN) parity ^d of the source word
//
// Optional feature macro: PAIR_SCHED_PARITY_EN
module pair_and_sched #(
  parameter int NREQ = 4,
  parameter int IDW  = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req,
  input  logic [4*NREQ-1:0] data,
  output logic [NREQ-1:0]   gnt,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [1:0]        out,
  output logic [IDW-1:0]    out_id,
  output logic              busy
`ifdef PAIR_SCHED_PARITY_EN
  ,
  output logic              out_par
`endif
);

  logic [IDW-1:0] r_ptr;
  logic           r_s1_valid;
  logic [3:0]     r_s1_data;
  logic [IDW-1:0] r_s1_id;
  logic           r_out_valid;
  logic [1:0]     r_out;
  logic [IDW-1:0] r_out_id;
`ifdef PAIR_SCHED_PARITY_EN
  logic           r_out_par;
`endif

  logic           w_adv;
  logic           w_found;
  logic [IDW-1:0] w_idx;
  logic           w_grant;
  logic [3:0]     w_word [NREQ];
  logic [3:0]     w_gnt_word;
  logic [IDW-1:0] w_ptr_next;

  // Whole pipeline moves together; a stalled output freezes stage 1 too,
  // even if it holds a bubble.
  assign w_adv = !r_out_valid || out_ready;

  // Rotating priority search starting at r_ptr. Only req and r_ptr feed this,
  // so there is no combinational path from data to gnt.
  always_comb begin
    int p;
    p       = 0;
    w_found = 1'b0;
    w_idx   = '0;
    for (int off = 0; off < NREQ; off++) begin
      p = int'(r_ptr) + off;
      if (p >= NREQ) begin
        p = p - NREQ;
      end
      if (!w_found && req[p]) begin
        w_found = 1'b1;
        w_idx   = IDW'(p);
      end
    end
  end

  // Held in reset, nothing is granted so no requester believes it was served.
  assign w_grant = w_adv && w_found && !rst;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_req
      assign w_word[gi] = data[4*gi +: 4];
      assign gnt[gi]    = w_grant && (w_idx == IDW'(gi));
    end
  endgenerate

  assign w_gnt_word = w_word[w_idx];
  assign w_ptr_next = (w_idx == IDW'(NREQ - 1)) ? '0 : w_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr       <= '0;
      r_s1_valid  <= 1'b0;
      r_s1_data   <= '0;
      r_s1_id     <= '0;
      r_out_valid <= 1'b0;
      r_out       <= '0;
      r_out_id    <= '0;
`ifdef PAIR_SCHED_PARITY_EN
      r_out_par   <= 1'b0;
`endif
    end else if (w_adv) begin
      if (w_grant) begin
        r_ptr <= w_ptr_next;
      end
      r_s1_valid  <= w_grant;
      r_s1_data   <= w_grant ? w_gnt_word : 4'h0;
      r_s1_id     <= w_grant ? w_idx : '0;
      r_out_valid <= r_s1_valid;
      // Bubbles clear the result fields so idle outputs read as zero.
      r_out       <= r_s1_valid ? {r_s1_data[3] & r_s1_data[2],
                                   r_s1_data[1] & r_s1_data[0]} : 2'b00;
      r_out_id    <= r_s1_valid ? r_s1_id : '0;
`ifdef PAIR_SCHED_PARITY_EN
      r_out_par   <= r_s1_valid ? ^r_s1_data : 1'b0;
`endif
    end
  end

  assign out_valid = r_out_valid;
  assign out       = r_out;
  assign out_id    = r_out_id;
  assign busy      = r_s1_valid || r_out_valid;
`ifdef PAIR_SCHED_PARITY_EN
  assign out_par   = r_out_par;
`endif

endmodule

// File: tb/tb_pair_and_sched.sv
// Self-checking bench for pair_and_sched: directed scenarios followed by
// randomized requester traffic with random backpressure. Expected results are
// queued when a grant is predicted and popped by an independent monitor when
// the DUT hands a result to the consumer.
module tb_pair_and_sched;
  localparam int NREQ = 4;
  localparam int IDW  = 2;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [NREQ-1:0]   req = '0;
  logic [4*NREQ-1:0] data = '0;
  logic [NREQ-1:0]   gnt;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [1:0]        out;
  logic [IDW-1:0]    out_id;
  logic              busy;
`ifdef PAIR_SCHED_PARITY_EN
  logic              out_par;
`endif

  pair_and_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .data      (data),
    .gnt       (gnt),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .out_id    (out_id),
    .busy      (busy)
`ifdef PAIR_SCHED_PARITY_EN
    ,
    .out_par   (out_par)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int o;
    int id;
    int par;
  } res_t;

  res_t exp_q[$];
  int   n_checks = 0;
  int   n_errs   = 0;

  // Reference state: who is next in line, and how many words are in each stage.
  int   m_ptr  = 0;
  bit   m_s1v  = 0;
  bit   m_ov   = 0;
  int   m_last = -1;
  int   waitc[NREQ];

  function automatic void chk(string name, logic [31:0] act, logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_errs++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, expv, $time);
    end
  endfunction

  // First requesting index at or after ptr, wrapping; -1 if none.
  function automatic int pick(logic [NREQ-1:0] r, int ptr);
    for (int off = 0; off < NREQ; off++) begin
      if (r[(ptr + off) % NREQ]) return (ptr + off) % NREQ;
    end
    return -1;
  endfunction

  // One clock: check at the falling edge, advance the model, return 1 ns after
  // the next rising edge so the caller may drive the following cycle.
  task automatic step();
    int       k;
    bit       adv;
    logic [3:0] w;
    res_t     r;
    @(negedge clk);
    if (rst) begin
      chk("gnt_in_reset", gnt, 0);
      m_ptr = 0; m_s1v = 0; m_ov = 0; m_last = -1;
      exp_q.delete();
      for (int i = 0; i < NREQ; i++) waitc[i] = 0;
    end else begin
      adv = !m_ov || out_ready;
      k   = adv ? pick(req, m_ptr) : -1;
      chk("gnt", gnt, (k >= 0) ? (32'd1 << k) : 32'd0);
      chk("out_valid", out_valid, m_ov);
      chk("busy", busy, m_s1v | m_ov);
      for (int i = 0; i < NREQ; i++) begin
        if (!req[i]) waitc[i] = 0;
        else if (k == i) begin
          chk("fairness_wait_ok", (waitc[i] <= NREQ - 1), 1);
          waitc[i] = 0;
        end else if (k >= 0) waitc[i]++;
      end
      if (k >= 0) begin
        w     = data[4*k +: 4];
        r.o   = {w[3] & w[2], w[1] & w[0]};
        r.id  = k;
        r.par = ^w;
        exp_q.push_back(r);
        m_ptr = (k + 1) % NREQ;
      end
      if (adv) begin
        m_ov  = m_s1v;
        m_s1v = (k >= 0);
      end
      m_last = k;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = '0; out_ready = 1'b0;
    step();
    rst = 1'b0;
  endtask

  // Requesters obey the contract: hold req/data until granted, may withdraw.
  task automatic rand_drive();
    for (int i = 0; i < NREQ; i++) begin
      if (m_last == i) begin
        req[i] = $urandom_range(1, 0);
        data[4*i +: 4] = 4'($urandom);
      end else if (req[i]) begin
        if ($urandom_range(15, 0) == 0) req[i] = 1'b0;
      end else if ($urandom_range(2, 0) == 0) begin
        req[i] = 1'b1;
        data[4*i +: 4] = 4'($urandom);
      end
    end
    out_ready = ($urandom_range(3, 0) != 0);
  endtask

  // Monitor: pops on every accepted result and checks stalls freeze the output.
  bit             hold_pend = 0;
  logic [1:0]     h_out;
  logic [IDW-1:0] h_id;
  always @(negedge clk) begin
    res_t r;
    if (!rst) begin
      if (hold_pend) begin
        chk("stall_valid_held", out_valid, 1);
        chk("stall_out_held", out, h_out);
        chk("stall_id_held", out_id, h_id);
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_errs++;
          $display("FAIL spurious_result: got id=%0d out=%0d, expected none", out_id, out);
        end else begin
          r = exp_q.pop_front();
          $display("result id=%0d out=%b (expected id=%0d out=%0d)", out_id, out, r.id, r.o);
          chk("result_out", out, r.o);
          chk("result_id", out_id, r.id);
`ifdef PAIR_SCHED_PARITY_EN
          chk("result_par", out_par, r.par);
`endif
        end
      end
    end
    hold_pend = !rst && out_valid && !out_ready;
    h_out = out;
    h_id  = out_id;
  end

  initial begin
    // Reset values, then an idle stretch.
    do_reset();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out", out, 0);
    chk("rst_out_id", out_id, 0);
    chk("rst_busy", busy, 0);
`ifdef PAIR_SCHED_PARITY_EN
    chk("rst_out_par", out_par, 0);
`endif
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      step();
      chk("idle_out", out, 0);
      chk("idle_out_id", out_id, 0);
    end

    // Single-word latency.
    req = 4'b0100; data[11:8] = 4'hD;
    #1 chk("lat_gnt", gnt, 4'b0100);
    step();
    req = '0;
    step();
    chk("lat_valid_n2", out_valid, 1);
    chk("lat_out_n2", out, 2'b10);
    chk("lat_id_n2", out_id, 2);
    step();
    chk("lat_valid_n3", out_valid, 0);

    // Round-robin at full rate, then a 3-cycle backpressure window.
    do_reset();
    out_ready = 1'b1;
    req = 4'b1111; data = {4'h0, 4'hC, 4'h3, 4'hF};
    for (int j = 0; j < 5; j++) begin
      #1 chk("rr_gnt", gnt, 32'd1 << (j % NREQ));
      step();
    end
    out_ready = 1'b0;
    for (int j = 0; j < 3; j++) begin
      #1 chk("bp_gnt_zero", gnt, 0);
      step();
    end
    out_ready = 1'b1;
    for (int j = 0; j < 6; j++) step();

    // Pointer wrap: after granting 3, requester 0 goes before 3.
    do_reset();
    out_ready = 1'b1;
    req = 4'b1000;
    #1 chk("wrap_gnt3", gnt, 4'b1000);
    step();
    req = 4'b1001;
    #1 chk("wrap_gnt0", gnt, 4'b0001);
    step();
    #1 chk("wrap_gnt3_again", gnt, 4'b1000);
    step();
    req = '0;
    step();

    // Reset with both stages full.
    req = 4'b1111;
    step(); step(); step();
    rst = 1'b1; req = '0; out_ready = 1'b0;
    step();
    rst = 1'b0;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    out_ready = 1'b1;
    req = 4'b0001; data[3:0] = 4'h7;
    step();
    req = '0;
    step();
    chk("par_word_valid", out_valid, 1);
    chk("par_word_out", out, 2'b01);
`ifdef PAIR_SCHED_PARITY_EN
    chk("par_word_par", out_par, 1);
`endif
    step();

    // Randomized traffic with random backpressure.
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rand_drive();
      step();
    end

    // Drain: every granted word must have come out exactly once.
    req = '0; out_ready = 1'b1;
    for (int c = 0; c < 4; c++) step();
    chk("drain_queue_empty", exp_q.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errs);
    $finish;
  end

endmodule
